conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequential 2-D convolution, one multiply-accumulate tap per cycle.
// Operands are latched on a conv_en rising edge; each output streams out as it finishes.
module conv_seq_ctrl #(
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int padding       = 0,
  parameter int stride        = 1,
  parameter int bitwidth      = 16,
  localparam int result_width  =
    (img_width - weight_width + 2 * padding) / stride + 1,
  localparam int result_height =
    (img_height - weight_height + 2 * padding) / stride + 1,
  localparam int R  = result_width * result_height,
  localparam int KK = weight_width * weight_height,
  localparam int NP = img_width * img_height,
  localparam int DW = 2 * bitwidth,
  localparam int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                     clk_en,
  input  logic                     rst_n,
  input  logic                     conv_en,
  input  logic [NP*bitwidth-1:0]   img,
  input  logic [KK*bitwidth-1:0]   weight,
  input  logic [bitwidth-1:0]      bias,
  output logic [R*DW-1:0]          result,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [IW-1:0]            out_idx,
  output logic                     busy,
  output logic                     conv_fin
);

  localparam int PW = $clog2(NP * bitwidth);
  localparam int WB = $clog2(KK * bitwidth);
  localparam int RB = $clog2(R * DW);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, STORE} state_t;

  state_t                   state;
  logic                     prev_en;
  logic [NP*bitwidth-1:0]   img_q;
  logic [KK*bitwidth-1:0]   w_q;
  logic [bitwidth-1:0]      b_q;
  logic [DW-1:0]            acc;
  int                       cur;
  int                       orow;
  int                       ocol;
  int                       krow;
  int                       kcol;

  logic signed [bitwidth-1:0] pix;
  logic signed [bitwidth-1:0] wt;
  logic signed [DW-1:0]       prod;
  logic [DW-1:0]              bext;
  logic [DW-1:0]              sum;

  // Taps landing in the zero border select no image bits at all.
  always_comb begin
    int y;
    int x;
    int pb;
    int wb;
    y   = orow * stride + krow - padding;
    x   = ocol * stride + kcol - padding;
    pb  = (NP - 1 - (y * img_width + x)) * bitwidth;
    wb  = (KK - 1 - (krow * weight_width + kcol)) * bitwidth;
    pix = '0;
    if (y >= 0 && y < img_height && x >= 0 && x < img_width)
      pix = img_q[PW'(pb) +: bitwidth];
    wt   = w_q[WB'(wb) +: bitwidth];
    prod = $signed({{bitwidth{pix[bitwidth-1]}}, pix})
         * $signed({{bitwidth{wt[bitwidth-1]}}, wt});
    bext = {{bitwidth{b_q[bitwidth-1]}}, b_q};
    sum  = acc + bext;
  end

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev_en   <= 1'b0;
      img_q     <= '0;
      w_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cur       <= 0;
      orow      <= 0;
      ocol      <= 0;
      krow      <= 0;
      kcol      <= 0;
      result    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      conv_fin  <= 1'b0;
    end else begin
      prev_en   <= conv_en;
      out_valid <= 1'b0;
      conv_fin  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (conv_en && !prev_en) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          img_q <= img;
          w_q   <= weight;
          b_q   <= bias;
          acc   <= '0;
          cur   <= 0;
          orow  <= 0;
          ocol  <= 0;
          krow  <= 0;
          kcol  <= 0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + prod;
          if (kcol == weight_width - 1) begin
            kcol <= 0;
            if (krow == weight_height - 1) begin
              krow  <= 0;
              state <= STORE;
            end else begin
              krow <= krow + 1;
            end
          end else begin
            kcol <= kcol + 1;
          end
        end
        STORE: begin
          result[RB'((R - 1 - cur) * DW) +: DW] <= sum;
          out_data  <= sum;
          out_idx   <= IW'(cur);
          out_valid <= 1'b1;
          acc       <= '0;
          if (cur == R - 1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            conv_fin <= 1'b1;
          end else begin
            cur   <= cur + 1;
            state <= MAC;
            if (ocol == result_width - 1) begin
              ocol <= 0;
              orow <= orow + 1;
            end else begin
              ocol <= ocol + 1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: default, padded and strided instances.
// Expected outputs are hand-computed from the 4x4 reference image.
module tb_conv_seq_ctrl;

  logic clk_en = 1'b0;
  logic rst_n;
  logic en0, en1, en2;

  always #5 clk_en = ~clk_en;

  localparam logic [255:0] IMG = {
    16'd3, 16'd2, 16'd4, 16'd1,
    16'd2, 16'd0, 16'd6, 16'd2,
    16'd6, 16'd7, 16'd1, 16'd2,
    16'd5, 16'd6, 16'd4, 16'd2};
  localparam logic [255:0] IMG_NEG = {16'hFFFD, 240'd0};
  localparam logic [63:0] W_DIAG = {16'd1, 16'd0, 16'd0, 16'd1};

  logic [255:0] img0;
  logic [63:0]  w0;
  logic [15:0]  b0_in;

  logic [287:0] res0;
  logic [799:0] res1;
  logic [127:0] res2;
  logic         v0, v1, v2, f0, f1, f2, b0, b1, b2;
  logic [31:0]  d0, d1, d2;
  logic [3:0]   i0;
  logic [4:0]   i1;
  logic [1:0]   i2;

  conv_seq_ctrl u_base (
    .clk_en(clk_en), .rst_n(rst_n), .conv_en(en0),
    .img(img0), .weight(w0), .bias(b0_in),
    .result(res0), .out_valid(v0), .out_data(d0),
    .out_idx(i0), .busy(b0), .conv_fin(f0));

  conv_seq_ctrl #(.padding(1)) u_pad (
    .clk_en(clk_en), .rst_n(rst_n), .conv_en(en1),
    .img(IMG), .weight({4{16'd1}}), .bias(16'd0),
    .result(res1), .out_valid(v1), .out_data(d1),
    .out_idx(i1), .busy(b1), .conv_fin(f1));

  conv_seq_ctrl #(.stride(2)) u_str (
    .clk_en(clk_en), .rst_n(rst_n), .conv_en(en2),
    .img(IMG), .weight(W_DIAG), .bias(16'd0),
    .result(res2), .out_valid(v2), .out_data(d2),
    .out_idx(i2), .busy(b2), .conv_fin(f2));

  int checks = 0;
  int errors = 0;
  int sel;
  logic vs, fs, bs;
  logic [31:0] ds;
  int isel;

  always_comb begin
    vs = v0; fs = f0; bs = b0; ds = d0; isel = int'(i0);
    if (sel == 1) begin
      vs = v1; fs = f1; bs = b1; ds = d1; isel = int'(i1);
    end else if (sel == 2) begin
      vs = v2; fs = f2; bs = b2; ds = d2; isel = int'(i2);
    end
  end

  int exp_b[9] = '{4, 9, 7, 10, 2, 9, 13, 12, 4};
  int exp_s[4] = '{3, 6, 12, 3};

  logic [31:0] got_data[32];
  int got_idx[32];
  int got_n[32];
  int nv, nfin, fin_n;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, expv);
    end
  endtask

  task automatic set_en(input int which, input logic val);
    case (which)
      0: en0 = val;
      1: en1 = val;
      default: en2 = val;
    endcase
  endtask

  // mode 0: one-cycle pulse; mode 1: held high with a glitch while busy
  task automatic run(input int which, input int mode, input int limit);
    sel = which;
    nv = 0; nfin = 0; fin_n = -1;
    @(negedge clk_en);
    set_en(which, 1'b1);
    @(posedge clk_en); #1;
    if (mode == 0) set_en(which, 1'b0);
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk_en); #1;
      if (mode == 1) set_en(which, n != 20);
      if (vs && nv < 32) begin
        got_data[nv] = ds; got_idx[nv] = isel; got_n[nv] = n;
        nv++;
      end
      if (fs) begin
        nfin++;
        if (fin_n < 0) fin_n = n;
      end
      if (mode == 0 && fin_n >= 0) break;
    end
  endtask

  task automatic check_base(input string tag);
    check({tag, "_nv"}, nv, 9);
    check({tag, "_fin"}, fin_n, 46);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_data"}, got_data[i], exp_b[i]);
      check({tag, "_idx"}, got_idx[i], i);
      check({tag, "_when"}, got_n[i], 6 + 5 * i);
      check({tag, "_res"}, res0[(8-i)*32 +: 32], exp_b[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; en0 = 0; en1 = 0; en2 = 0; sel = 0;
    img0 = IMG; w0 = W_DIAG; b0_in = 16'd1;
    repeat (3) @(posedge clk_en);
    #1;
    check("rst_busy", b0, 0);
    check("rst_valid", v0, 0);
    check("rst_fin", f0, 0);
    check("rst_data", d0, 0);
    check("rst_idx", i0, 0);
    check("rst_res", |res0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_en);

    run(0, 0, 80);
    check_base("base");
    check("base_idle", b0, 0);

    img0 = IMG_NEG; w0 = {16'd2, 48'd0}; b0_in = 16'hFFFF;
    run(0, 0, 80);
    check("neg_fin", fin_n, 46);
    check("neg_d0", got_data[0], 32'hFFFF_FFF9);
    check("neg_d1", got_data[1], 32'hFFFF_FFFF);

    img0 = IMG; w0 = W_DIAG; b0_in = 16'd1;
    repeat (2) @(posedge clk_en);
    run(0, 1, 60);
    check("hold_nfin", nfin, 1);
    check_base("hold");
    check("hold_norestart", b0, 0);
    @(negedge clk_en); en0 = 1'b0;
    repeat (2) @(posedge clk_en);
    run(0, 0, 80);
    check_base("rerun");

    @(negedge clk_en); en0 = 1'b1;
    @(posedge clk_en); #1; en0 = 1'b0;
    repeat (3) @(posedge clk_en);
    #1;
    check("abort_busy_pre", b0, 1);
    rst_n = 1'b0;
    @(posedge clk_en); #1;
    rst_n = 1'b1;
    check("abort_busy", b0, 0);
    nv = 0; nfin = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk_en); #1;
      if (v0) nv++;
      if (f0) nfin++;
    end
    check("abort_nv", nv, 0);
    check("abort_nfin", nfin, 0);
    check("abort_res", |res0, 0);
    run(0, 0, 80);
    check_base("after_abort");

    run(1, 0, 200);
    check("pad_nv", nv, 25);
    check("pad_fin", fin_n, 126);
    check("pad_00", got_data[0], 3);
    check("pad_01", got_data[1], 5);
    check("pad_33", got_data[18], 9);
    check("pad_44", got_data[24], 2);
    check("pad_last_idx", got_idx[24], 24);

    run(2, 0, 60);
    check("str_nv", nv, 4);
    check("str_fin", fin_n, 21);
    for (int i = 0; i < 4; i++) begin
      check("str_data", got_data[i], exp_s[i]);
      check("str_res", res2[(3-i)*32 +: 32], exp_s[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
